// File: rtl/cdc_4phase_src.sv
// ----------------------------------------------------------------------------
// cdc_4phase_src
// Source (transmitter) half of a four-phase req/ack clock-domain crossing.
// A word accepted on the valid/ready side is registered onto async_data_o.
// async_req_o is raised on the same edge. The block then waits for the
// synchronized acknowledge, drops the request, and waits for the acknowledge
// to return low before it accepts the next word.
//
// Ports:
//   clk_i         source-domain clock
//   rst_ni        asynchronous active-low reset
//   valid_i       source presents a word on data_i
//   ready_o       block accepts a word this cycle (depends on flops only)
//   data_i        word to transfer
//   busy_o        handshake in progress
//   async_req_o   request level to the destination, straight from a flop
//   async_ack_i   acknowledge level from the destination (asynchronous)
//   async_data_o  data to the destination, straight from flops
// ----------------------------------------------------------------------------
module cdc_4phase_src #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             busy_o,
  output logic             async_req_o,
  input  logic             async_ack_i,
  output logic [WIDTH-1:0] async_data_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("cdc_4phase_src: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_sync;
  logic                   accept;

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];

  // A stale ack that is still high, left by the previous handshake or by an
  // asymmetric reset, blocks a new transfer even in IDLE.
  assign ready_o      = (state_q == ST_IDLE) && !ack_sync;
  assign accept       = valid_i && ready_o;
  assign busy_o       = (state_q != ST_IDLE);
  assign async_req_o  = req_q;
  assign async_data_o = data_q;

  // Multi-flop synchronizer bringing the destination ack into clk_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], async_ack_i};
    end
  end

  // State, request and data registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic of the handshake FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_REQ;
        else        state_d = ST_IDLE;
      end
      ST_REQ: begin
        // A falling ack while in REQ is ignored; only a high ack moves on.
        if (ack_sync) state_d = ST_RELEASE;
        else          state_d = ST_REQ;
      end
      ST_RELEASE: begin
        if (!ack_sync) state_d = ST_IDLE;
        else           state_d = ST_RELEASE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the request and data flops.
  always_comb begin
    req_d  = req_q;
    data_d = data_q;
    case (state_q)
      ST_IDLE: begin
        // Data is loaded only here, while req and ack_sync are both low, so
        // it is stable for the entire req-high and release phases.
        if (accept) begin
          req_d  = 1'b1;
          data_d = data_i;
        end else begin
          req_d  = 1'b0;
          data_d = data_q;
        end
      end
      ST_REQ: begin
        if (ack_sync) req_d = 1'b0;
        else          req_d = 1'b1;
      end
      ST_RELEASE: begin
        req_d = 1'b0;
      end
      default: begin
        req_d  = 1'b0;
        data_d = data_q;
      end
    endcase
  end

endmodule

// File: tb/tb_cdc_4phase_src.sv
module tb_cdc_4phase_src;

  localparam int SA = 2;  // sync stages of instance A
  localparam int SB = 3;  // sync stages of instance B

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_valid, a_ack;
  logic [31:0] a_data;
  logic        a_ready, a_busy, a_req;
  logic [31:0] a_adata;
  logic        b_valid, b_ack;
  logic [31:0] b_data;
  logic        b_ready, b_busy, b_req;
  logic [31:0] b_adata;

  cdc_4phase_src #(.WIDTH(32), .SYNC_STAGES(SA)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid), .ready_o(a_ready),
    .data_i(a_data), .busy_o(a_busy), .async_req_o(a_req),
    .async_ack_i(a_ack), .async_data_o(a_adata)
  );

  cdc_4phase_src #(.WIDTH(32), .SYNC_STAGES(SB)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid), .ready_o(b_ready),
    .data_i(b_data), .busy_o(b_busy), .async_req_o(b_req),
    .async_ack_i(b_ack), .async_data_o(b_adata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model of instance A, built from the transfer rules:
  // the block sees the ack SA edges late; a word is taken when idle and the
  // delayed ack is low; req drops when the delayed ack is seen high; the
  // transfer finishes once the delayed ack is seen low again.
  bit          m_busy, m_req;
  logic [31:0] m_data;
  bit          hist[$];   // hist[i] = ack sampled i+1 edges ago
  bit          auto_a;
  int          cnt_a;
  int          lat_max;

  task automatic model_reset();
    m_busy = 1'b0;
    m_req  = 1'b0;
    m_data = 32'd0;
    hist.delete();
    for (int i = 0; i < SA; i++) hist.push_back(1'b0);
  endtask

  task automatic check_a(input string tag);
    chk({tag, "_req"},   32'(a_req),   32'(m_req));
    chk({tag, "_data"},  a_adata,      m_data);
    chk({tag, "_busy"},  32'(a_busy),  32'(m_busy));
    chk({tag, "_ready"}, 32'(a_ready), 32'(!m_busy && !hist[SA-1]));
  endtask

  // One clock of instance A: model update at the edge, compare at negedge,
  // then the optional far-end responder drives the next ack level.
  task automatic step_a(input string tag);
    bit seen;
    @(posedge clk);
    if (rst_n) begin
      seen = hist[SA-1];
      if (!m_busy) begin
        if (!seen && a_valid) begin
          m_busy = 1'b1;
          m_req  = 1'b1;
          m_data = a_data;
        end
      end else if (m_req) begin
        if (seen) m_req = 1'b0;
      end else if (!seen) begin
        m_busy = 1'b0;
      end
      hist.push_front(a_ack);
      void'(hist.pop_back());
    end
    @(negedge clk);
    check_a(tag);
    if (auto_a && (a_req !== a_ack)) begin
      if (cnt_a == 0) begin
        a_ack = a_req;
        cnt_a = (lat_max == 0) ? 0 : int'($urandom_range(lat_max, 0));
      end else begin
        cnt_a--;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int          n, pulses;
  bit          prev;
  logic [31:0] got_q[$];

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_ack = 1'b0; a_data = 32'd0;
    b_valid = 1'b0; b_ack = 1'b0; b_data = 32'd0;
    auto_a = 1'b0; cnt_a = 0; lat_max = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    // 1. reset values
    check_a("reset");
    chk("reset_b_ready", 32'(b_ready), 32'd1);
    chk("reset_b_req",   32'(b_req),   32'd0);
    chk("reset_b_data",  b_adata,      32'd0);
    chk("reset_b_busy",  32'(b_busy),  32'd0);
    @(negedge clk);

    // 2. single transfer with a one-cycle far end
    a_valid = 1'b1; a_data = 32'hA5A5_0F0F;
    step_a("t2_accept");
    chk("t2_req_after_edge0", 32'(a_req), 32'd1);
    chk("t2_data_after_edge0", a_adata, 32'hA5A5_0F0F);
    a_valid = 1'b0; a_data = 32'h0;
    a_ack = 1'b1;
    n = 0;
    while (a_req && n < 20) begin step_a("t2_wait_ack"); n++; end
    chk("t2_req_fall_edges", 32'(n), 32'd3);
    a_ack = 1'b0;
    n = 0;
    while (!a_ready && n < 20) begin step_a("t2_wait_ready"); n++; end
    chk("t2_ready_edges", 32'(n), 32'd3);
    chk("t2_data_held", a_adata, 32'hA5A5_0F0F);

    // 3. back-to-back with valid held high
    auto_a = 1'b1; lat_max = 0;
    a_valid = 1'b1; a_data = 32'd1;
    pulses = 0; prev = a_req; n = 0;
    while (got_q.size() < 3 && n < 200) begin
      step_a("t3_run");
      if (a_req && !prev) begin
        pulses++;
        got_q.push_back(a_adata);
        a_data = 32'(got_q.size() + 1);
      end
      prev = a_req; n++;
    end
    a_valid = 1'b0;
    repeat (30) begin
      step_a("t3_drain");
      if (a_req && !prev) pulses++;
      prev = a_req;
    end
    chk("t3_pulses", 32'(pulses), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("t3_word", (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF, 32'(i + 1));

    // 4. stale ack held through reset release
    auto_a = 1'b0;
    rst_n = 1'b0; a_ack = 1'b1;
    model_reset();
    step_a("t4_in_reset");
    rst_n = 1'b1;
    repeat (SA) step_a("t4_settle");
    a_valid = 1'b1; a_data = 32'h55;
    repeat (4) step_a("t4_blocked");
    chk("t4_ready_low", 32'(a_ready), 32'd0);
    chk("t4_no_req", 32'(a_req), 32'd0);
    a_ack = 1'b0;
    n = 0;
    while (!a_ready && n < 20) begin step_a("t4_wait_ready"); n++; end
    chk("t4_ready_edges", 32'(n), 32'(SA));
    auto_a = 1'b1; lat_max = 1;
    step_a("t4_accept");
    chk("t4_req", 32'(a_req), 32'd1);
    chk("t4_data", a_adata, 32'h55);
    a_valid = 1'b0;
    repeat (20) step_a("t4_finish");
    chk("t4_idle", 32'(a_busy), 32'd0);

    // random traffic against the model
    lat_max = 3;
    repeat (400) begin
      a_valid = 1'($urandom_range(1, 0));
      a_data  = $urandom;
      step_a("rnd");
    end
    a_valid = 1'b0;
    n = 0;
    while (a_busy && n < 100) begin step_a("rnd_drain"); n++; end
    chk("rnd_drained", 32'(a_busy), 32'd0);
    repeat (SA + 2) step_a("rnd_settle");

    // 5. reset in the middle of a handshake
    auto_a = 1'b0; a_ack = 1'b0;
    a_valid = 1'b1; a_data = 32'hDEAD_BEEF;
    step_a("t5_accept");
    a_valid = 1'b0;
    step_a("t5_req");
    chk("t5_in_req", 32'(a_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_req_async", 32'(a_req), 32'd0);
    chk("t5_data_async", a_adata, 32'd0);
    chk("t5_busy_async", 32'(a_busy), 32'd0);
    model_reset();
    step_a("t5_hold");
    rst_n = 1'b1;
    step_a("t5_after");
    chk("t5_ready", 32'(a_ready), 32'd1);

    // 6. slow destination on the three-stage instance
    b_valid = 1'b1; b_data = 32'h1234_5678;
    tick();
    chk("t6_req", 32'(b_req), 32'd1);
    b_valid = 1'b0;
    for (int i = 0; i < 22; i++) begin
      b_valid = 1'($urandom_range(1, 0));
      b_data  = $urandom;
      tick();
      chk("t6_req_held", 32'(b_req), 32'd1);
      chk("t6_data_held", b_adata, 32'h1234_5678);
      chk("t6_ready_low", 32'(b_ready), 32'd0);
    end
    b_valid = 1'b0;
    b_ack = 1'b1;
    n = 0;
    while (b_req && n < 20) begin tick(); n++; end
    chk("t6_req_fall_edges", 32'(n), 32'(SB + 1));
    b_ack = 1'b0;
    n = 0;
    while (!b_ready && n < 20) begin tick(); n++; end
    chk("t6_ready_edges", 32'(n), 32'(SB + 1));
    chk("t6_data_final", b_adata, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
